// File: rtl/mem_ctrl.sv
// MEM-stage load/store controller: alignment check, req/ack data-bus transaction,
// load extraction with sign/zero extension and a stall request while the bus is busy.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_en,
  input  logic [3:0]        ex_mem_op,
  input  logic [DATA_W-1:0] ex_out,
  input  logic [DATA_W-1:0] ex_mem_wr_data,
  input  logic              flush,
  output logic [DATA_W-1:0] out,
  output logic              miss_align,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_rw,
  output logic [ADDR_W-3:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_ack
);

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLbu = 4'd2;
  localparam logic [3:0] OpLh  = 4'd3;
  localparam logic [3:0] OpLhu = 4'd4;
  localparam logic [3:0] OpLw  = 4'd5;
  localparam logic [3:0] OpSb  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSw  = 4'd8;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_t;

  state_t            state_q;
  logic              kill_q;
  logic [3:0]        op_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] result_q;

  logic              is_load;
  logic              is_mem;
  logic              sz_byte;
  logic              sz_half;
  logic              sz_word;
  logic              start;
  logic [3:0]        be_new;
  logic [DATA_W-1:0] wd_new;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] ld_data;

  // Decode of the incoming EX/MEM operation.
  always_comb begin
    is_load = 1'b0;
    sz_byte = 1'b0;
    sz_half = 1'b0;
    sz_word = 1'b0;
    unique case (ex_mem_op)
      OpLb, OpLbu: begin is_load = 1'b1; sz_byte = 1'b1; end
      OpLh, OpLhu: begin is_load = 1'b1; sz_half = 1'b1; end
      OpLw:        begin is_load = 1'b1; sz_word = 1'b1; end
      OpSb:        sz_byte = 1'b1;
      OpSh:        sz_half = 1'b1;
      OpSw:        sz_word = 1'b1;
      default:     ;
    endcase
    is_mem = sz_byte | sz_half | sz_word;
  end

  assign miss_align = ex_en & ((sz_half & ex_out[0]) | (sz_word & (ex_out[1:0] != 2'b00)));
  assign start      = (state_q == StIdle) & ex_en & is_mem & ~miss_align & ~flush;

  // Byte enables and lane-replicated write data for the access about to start.
  always_comb begin
    be_new = 4'b0000;
    wd_new = ex_mem_wr_data;
    if (sz_byte) begin
      be_new = 4'b0001 << ex_out[1:0];
      wd_new = {4{ex_mem_wr_data[7:0]}};
    end else if (sz_half) begin
      be_new = ex_out[1] ? 4'b1100 : 4'b0011;
      wd_new = {2{ex_mem_wr_data[15:0]}};
    end else if (sz_word) begin
      be_new = 4'b1111;
    end
  end

  // Load extraction uses the latched op and lane, not the live EX/MEM inputs.
  always_comb begin
    rd_byte = bus_rd_data[7:0];
    unique case (lane_q)
      2'd0: rd_byte = bus_rd_data[7:0];
      2'd1: rd_byte = bus_rd_data[15:8];
      2'd2: rd_byte = bus_rd_data[23:16];
      2'd3: rd_byte = bus_rd_data[31:24];
      default: ;
    endcase
    rd_half = lane_q[1] ? bus_rd_data[31:16] : bus_rd_data[15:0];
    ld_data = '0;
    case (op_q)
      OpLb:    ld_data = {{24{rd_byte[7]}}, rd_byte};
      OpLbu:   ld_data = {24'd0, rd_byte};
      OpLh:    ld_data = {{16{rd_half[15]}}, rd_half};
      OpLhu:   ld_data = {16'd0, rd_half};
      OpLw:    ld_data = bus_rd_data;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    out  = '0;
    unique case (state_q)
      StIdle: begin
        busy = start;
        out  = is_mem ? '0 : ex_out;
      end
      StReq: begin
        busy = 1'b1;
        out  = '0;
      end
      StDone: begin
        busy = 1'b0;
        out  = result_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      bus_req     <= 1'b0;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_be      <= 4'b0000;
      bus_wr_data <= '0;
      result_q    <= '0;
      kill_q      <= 1'b0;
      op_q        <= 4'd0;
      lane_q      <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          kill_q <= 1'b0;
          if (start) begin
            state_q     <= StReq;
            bus_req     <= 1'b1;
            bus_rw      <= is_load;
            bus_addr    <= ex_out[ADDR_W-1:2];
            bus_be      <= be_new;
            bus_wr_data <= wd_new;
            op_q        <= ex_mem_op;
            lane_q      <= ex_out[1:0];
          end
        end
        StReq: begin
          if (flush) kill_q <= 1'b1;
          if (bus_ack) begin
            bus_req <= 1'b0;
            // A flush seen in the ack cycle itself also kills the access.
            if (kill_q || flush) begin
              state_q <= StIdle;
              kill_q  <= 1'b0;
            end else begin
              state_q  <= StDone;
              result_q <= ld_data;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl with a behavioural bus slave
// and an arithmetic reference model of alignment, lanes and load extension.
module tb_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        ex_en;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_out;
  logic [31:0] ex_mem_wr_data;
  logic        flush;
  logic [31:0] out;
  logic        miss_align;
  logic        busy;
  logic        bus_req;
  logic        bus_rw;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_ack;

  int n_total;
  int n_bad;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_en          (ex_en),
    .ex_mem_op      (ex_mem_op),
    .ex_out         (ex_out),
    .ex_mem_wr_data (ex_mem_wr_data),
    .flush          (flush),
    .out            (out),
    .miss_align     (miss_align),
    .busy           (busy),
    .bus_req        (bus_req),
    .bus_rw         (bus_rw),
    .bus_addr       (bus_addr),
    .bus_be         (bus_be),
    .bus_wr_data    (bus_wr_data),
    .bus_rd_data    (bus_rd_data),
    .bus_ack        (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: access size in bytes (0 = not a memory op).
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit op_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic [3:0] model_be(input int sz, input logic [31:0] addr);
    logic [7:0] m;
    m = 8'(((1 << sz) - 1) << (addr % 4));
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wd(input int sz, input logic [31:0] d);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int sz;
    logic [63:0] mask;
    logic [63:0] v;
    sz   = op_size(op);
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v    = ({32'd0, rd} >> (8 * (addr % 4))) & mask;
    if ((op == 4'd1 || op == 4'd3) && v[8*sz-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Entered just after a negedge; returns just after a negedge with the DUT idle.
  task automatic do_txn(input bit en, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input int flush_at, input bit flush_start);
    int          sz;
    bit          mis;
    bit          start;
    bit          killed;
    bit          acked;
    logic [31:0] sentinel;
    sz    = op_size(op);
    mis   = en && (sz > 1) && ((addr % sz) != 0);
    start = en && (sz != 0) && !mis && !flush_start;
    ex_en          = en;
    ex_mem_op      = op;
    ex_out         = addr;
    ex_mem_wr_data = wd;
    flush          = flush_start;
    bus_ack        = start ? 1'b0 : 1'($urandom_range(0, 1));
    bus_rd_data    = $urandom;
    #1;
    check_eq("miss_align", 32'(miss_align), 32'(mis));
    check_eq("busy_issue", 32'(busy), 32'(start));
    if (!start) begin
      if (en && sz == 0) check_eq("out_pass", out, addr);
      if (mis)           check_eq("out_misalign", out, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check_eq("no_req", 32'(bus_req), 32'd0);
      flush   = 1'b0;
      bus_ack = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    killed = 1'b0;
    acked  = 1'b0;
    flush  = 1'b0;
    for (int c = 0; c < 20 && !acked; c++) begin
      flush = (c == flush_at);
      if (flush) killed = 1'b1;
      #1;
      check_eq("req_high", 32'(bus_req), 32'd1);
      check_eq("busy_req", 32'(busy), 32'd1);
      check_eq("bus_addr", 32'(bus_addr), addr >> 2);
      check_eq("bus_rw", 32'(bus_rw), 32'(op_is_load(op)));
      check_eq("bus_be", 32'(bus_be), 32'(model_be(sz, addr)));
      if (!op_is_load(op)) check_eq("bus_wr_data", bus_wr_data, model_wd(sz, wd));
      if (c == waits) begin
        bus_ack     = 1'b1;
        bus_rd_data = rd;
        acked       = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      bus_ack     = 1'b0;
      flush       = 1'b0;
      bus_rd_data = $urandom;
    end
    if (!acked) check_eq("ack_timeout", 32'd0, 32'd1);
    sentinel  = $urandom;
    ex_en     = 1'b0;
    ex_mem_op = 4'd0;
    ex_out    = sentinel;
    #1;
    check_eq("req_drop", 32'(bus_req), 32'd0);
    check_eq("busy_after", 32'(busy), 32'd0);
    if (killed) check_eq("out_killed", out, sentinel);
    else if (op_is_load(op)) check_eq("out_load", out, model_load(op, addr, rd));
    else check_eq("out_store", out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("back_idle", out, sentinel);
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    reset          = 1'b0;
    ex_en          = 1'b0;
    ex_mem_op      = 4'd0;
    ex_out         = 32'd0;
    ex_mem_wr_data = 32'd0;
    flush          = 1'b0;
    bus_rd_data    = 32'd0;
    bus_ack        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_req", 32'(bus_req), 32'd0);
    check_eq("rst_rw", 32'(bus_rw), 32'd1);
    check_eq("rst_addr", 32'(bus_addr), 32'd0);
    check_eq("rst_be", 32'(bus_be), 32'd0);
    check_eq("rst_wd", bus_wr_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out", out, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    do_txn(1, 4'd5, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, -1, 0);
    do_txn(1, 4'd1, 32'h103, 32'h0, 32'h80FF_0011, 0, -1, 0);
    do_txn(1, 4'd2, 32'h103, 32'h0, 32'h80FF_0011, 1, -1, 0);
    do_txn(1, 4'd7, 32'h202, 32'h1234_ABCD, 32'h0, 2, -1, 0);
    do_txn(1, 4'd5, 32'h101, 32'h0, 32'h0, 0, -1, 0);
    do_txn(1, 4'd0, 32'h55, 32'h0, 32'h0, 0, -1, 0);
    do_txn(1, 4'd3, 32'h302, 32'h0, 32'h0000_8001, 3, 1, 0);
    do_txn(1, 4'd8, 32'h40, 32'h1111_2222, 32'h0, 0, -1, 1);

    // Reset asserted while a request is outstanding.
    ex_en     = 1'b1;
    ex_mem_op = 4'd5;
    ex_out    = 32'h40;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("pre_rst_req", 32'(bus_req), 32'd1);
    ex_en = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(bus_req), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_txn(1, 4'd6, 32'h1, 32'h0000_00A5, 32'h0, 1, -1, 0);

    for (int i = 0; i < 80; i++) begin
      logic [3:0]  op;
      logic [31:0] addr;
      int          sz;
      int          waits;
      int          fa;
      op    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      addr  = $urandom;
      sz    = op_size(op);
      if (sz > 1 && $urandom_range(0, 1) == 1) addr = addr & ~(32'(sz) - 32'd1);
      waits = $urandom_range(0, 4);
      fa    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, waits) : -1;
      do_txn($urandom_range(0, 9) != 0, op, addr, $urandom, $urandom, waits, fa,
             $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
